// File: rtl/arb_pkg.sv
// arb_pkg: shared types and defaults for the burst requester.
// Channel state encoding plus default field widths and timeout.
package arb_pkg;

  localparam int LEN_W_DEF  = 4;
  localparam int TO_CYC_DEF = 200;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    OWN  = 2'd2,
    GAP  = 2'd3
  } chan_st_e;

  // True when the channel is presenting a request to the arbiter.
  function automatic logic st_req(input chan_st_e s);
    return (s == WAIT) || (s == OWN);
  endfunction

endpackage

// File: rtl/arb_requester_if.sv
// arb_requester_if: one client/arbiter channel bundle.
// slave = requester side; master = client + arbiter side.
interface arb_requester_if
  import arb_pkg::*;
#(
  parameter int LEN_W = LEN_W_DEF
);

  logic             cmd_valid;
  logic             cmd_ready;
  logic [LEN_W-1:0] cmd_len;
  logic             req;
  logic             gnt;
  logic             done;
  logic             to;

  modport slave (
    input  cmd_valid,
    input  cmd_len,
    input  gnt,
    output cmd_ready,
    output req,
    output done,
    output to
  );

  modport master (
    output cmd_valid,
    output cmd_len,
    output gnt,
    input  cmd_ready,
    input  req,
    input  done,
    input  to
  );

endinterface

// File: rtl/arb_req_chan.sv
// arb_req_chan: one burst-request channel (IDLE/WAIT/OWN/GAP).
// Ports: clk, rst_n (async, active low), ch (slave modport).
// Optional grant-wait timeout: define REQ_TIMEOUT_EN.
module arb_req_chan
  import arb_pkg::*;
#(
  parameter int LEN_W  = LEN_W_DEF,
  parameter int TO_CYC = TO_CYC_DEF
) (
  input  logic clk,
  input  logic rst_n,
  arb_requester_if.slave ch
);

  chan_st_e         state;
  chan_st_e         nxt;
  logic [LEN_W-1:0] cnt;
  logic [LEN_W-1:0] cnt_nxt;
  logic             last;
  logic             to_hit;

  assign last = (cnt == '0);

`ifdef REQ_TIMEOUT_EN
  localparam int TW = $clog2(TO_CYC + 1);

  logic [TW-1:0] to_cnt;

  // Counts consecutive grant-less WAIT cycles; idles at zero
  // outside WAIT, so every entry into WAIT starts fresh.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      to_cnt <= '0;
    end else if (state != WAIT || ch.gnt) begin
      to_cnt <= '0;
    end else begin
      to_cnt <= to_cnt + 1'b1;
    end
  end

  assign to_hit = (state == WAIT) && !ch.gnt &&
                  (to_cnt == TW'(TO_CYC - 1));
`else
  // Timeout feature absent: constant-false for any legal TO_CYC.
  assign to_hit = (TO_CYC < 0);
`endif

  assign ch.to = to_hit;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    nxt          = state;
    cnt_nxt      = cnt;
    ch.cmd_ready = 1'b0;
    ch.done      = 1'b0;
    ch.req       = st_req(state);
    unique case (state)
      IDLE: begin
        ch.cmd_ready = 1'b1;
        if (ch.cmd_valid) begin
          cnt_nxt = ch.cmd_len;
          nxt     = WAIT;
        end
      end
      WAIT: begin
        if (ch.gnt) begin
          if (last) begin
            ch.done = 1'b1;
            nxt     = GAP;
          end else begin
            cnt_nxt = cnt - 1'b1;
            nxt     = OWN;
          end
        end else if (to_hit) begin
          cnt_nxt = '0;
          nxt     = GAP;
        end
      end
      OWN: begin
        if (ch.gnt) begin
          if (last) begin
            ch.done = 1'b1;
            nxt     = GAP;
          end else begin
            cnt_nxt = cnt - 1'b1;
          end
        end else begin
          // Preempted: keep the remaining count and re-request.
          nxt = WAIT;
        end
      end
      GAP: begin
        nxt = IDLE;
      end
      default: begin
        nxt = IDLE;
      end
    endcase
  end

endmodule

// File: rtl/arb_requester.sv
// arb_requester: two independent burst-request channels.
// Ports: clk, rst_n (async, active low), ch0/ch1 (slave modports).
// Optional grant-wait timeout: define REQ_TIMEOUT_EN.
module arb_requester
  import arb_pkg::*;
#(
  parameter int LEN_W  = LEN_W_DEF,
  parameter int TO_CYC = TO_CYC_DEF
) (
  input  logic clk,
  input  logic rst_n,
  arb_requester_if.slave ch0,
  arb_requester_if.slave ch1
);

  arb_req_chan #(
    .LEN_W (LEN_W),
    .TO_CYC(TO_CYC)
  ) u_ch0 (
    .clk  (clk),
    .rst_n(rst_n),
    .ch   (ch0)
  );

  arb_req_chan #(
    .LEN_W (LEN_W),
    .TO_CYC(TO_CYC)
  ) u_ch1 (
    .clk  (clk),
    .rst_n(rst_n),
    .ch   (ch1)
  );

endmodule

// File: tb/tb_arb_requester.sv
// tb_arb_requester: directed bench for arb_requester.
// Scripted grants plus a small locking two-requester arbiter.
module tb_arb_requester;

  logic clk = 1'b0;
  logic rst_n;
  int   n_chk  = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  arb_requester_if #(.LEN_W(4)) if0 ();
  arb_requester_if #(.LEN_W(4)) if1 ();

  arb_requester #(
    .LEN_W (4),
    .TO_CYC(8)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .ch0  (if0),
    .ch1  (if1)
  );

  // Grant source: scripted or the arbiter.
  logic use_arb = 1'b0;
  logic sg0 = 1'b0;
  logic sg1 = 1'b0;
  logic ag0, ag1;
  logic own = 1'b0;

  always_comb begin
    ag0 = 1'b0;
    ag1 = 1'b0;
    if (!own && if0.req)      ag0 = 1'b1;
    else if (own && if1.req)  ag1 = 1'b1;
    else if (if0.req)         ag0 = 1'b1;
    else if (if1.req)         ag1 = 1'b1;
  end

  always @(posedge clk) begin
    if (ag0)      own <= 1'b0;
    else if (ag1) own <= 1'b1;
  end

  assign if0.gnt = use_arb ? ag0 : sg0;
  assign if1.gnt = use_arb ? ag1 : sg1;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  int  grants, dones, done_at, tos, to_at, both, reqs;
  int  d0, d1;
  logic drop, gap0, gap1, pd0, pd1, req9;
  bit  gp [9] = '{1, 1, 0, 0, 0, 1, 1, 1, 1};

  initial begin
    rst_n         = 1'b0;
    if0.cmd_valid = 1'b0;
    if0.cmd_len   = '0;
    if1.cmd_valid = 1'b0;
    if1.cmd_len   = '0;

    // Reset state
    #2;
    chk("rst_rdy0", if0.cmd_ready, 1);
    chk("rst_req0", if0.req, 0);
    chk("rst_done0", if0.done, 0);
    chk("rst_to0", if0.to, 0);
    chk("rst_rdy1", if1.cmd_ready, 1);
    chk("rst_req1", if1.req, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Single burst len=3, grant held (also in IDLE/GAP)
    @(negedge clk);
    if0.cmd_valid = 1'b1;
    if0.cmd_len   = 4'd3;
    sg0 = 1'b1;
    #1;
    chk("b1_idle_rdy", if0.cmd_ready, 1);
    chk("b1_idle_req", if0.req, 0);
    chk("b1_idle_done", if0.done, 0);
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      if0.cmd_valid = 1'b1;
      if0.cmd_len   = 4'd0;
      #1;
      chk($sformatf("b1_req_k%0d", k), if0.req, 1);
      chk($sformatf("b1_rdy_k%0d", k), if0.cmd_ready, 0);
      chk($sformatf("b1_done_k%0d", k), if0.done, (k == 4));
    end
    @(negedge clk);
    if0.cmd_valid = 1'b0;
    #1;
    chk("b1_gap_req", if0.req, 0);
    chk("b1_gap_rdy", if0.cmd_ready, 0);
    chk("b1_gap_done", if0.done, 0);
    @(negedge clk);
    #1;
    chk("b1_idle2_rdy", if0.cmd_ready, 1);
    chk("b1_idle2_req", if0.req, 0);

    // len=0: done on the single WAIT grant
    @(negedge clk);
    if0.cmd_valid = 1'b1;
    if0.cmd_len   = 4'd0;
    @(negedge clk);
    if0.cmd_valid = 1'b0;
    #1;
    chk("l0_req", if0.req, 1);
    chk("l0_done", if0.done, 1);
    @(negedge clk);
    #1;
    chk("l0_gap_req", if0.req, 0);
    chk("l0_gap_done", if0.done, 0);

    // len=15: 16 grant cycles
    @(negedge clk);
    if0.cmd_valid = 1'b1;
    if0.cmd_len   = 4'd15;
    @(negedge clk);
    if0.cmd_valid = 1'b0;
    grants = 0; dones = 0; done_at = 0;
    for (int k = 1; k <= 20; k++) begin
      #1;
      if (if0.req) grants++;
      if (if0.done) begin dones++; done_at = k; end
      @(negedge clk);
    end
    sg0 = 1'b0;
    chk("l15_grants", grants, 16);
    chk("l15_dones", dones, 1);
    chk("l15_done_at", done_at, 16);

    // Preemption on channel 1, len=5
    @(negedge clk);
    if1.cmd_valid = 1'b1;
    if1.cmd_len   = 4'd5;
    @(negedge clk);
    if1.cmd_valid = 1'b0;
    grants = 0; dones = 0; done_at = 0; drop = 1'b0;
    for (int k = 0; k < 9; k++) begin
      sg1 = gp[k];
      #1;
      if (!if1.req) drop = 1'b1;
      if (if1.req && if1.gnt) grants++;
      if (if1.done) begin dones++; done_at = k; end
      @(negedge clk);
    end
    sg1 = 1'b0;
    #1;
    chk("pre_grants", grants, 6);
    chk("pre_dones", dones, 1);
    chk("pre_done_at", done_at, 8);
    chk("pre_drop", drop, 0);
    chk("pre_gap_req", if1.req, 0);
    chk("pre_ch0_idle", if0.cmd_ready, 1);

    // Contention through the arbiter, len=2 on both
    @(negedge clk);
    @(negedge clk);
    use_arb = 1'b1;
    if0.cmd_valid = 1'b1;
    if0.cmd_len   = 4'd2;
    if1.cmd_valid = 1'b1;
    if1.cmd_len   = 4'd2;
    @(negedge clk);
    if0.cmd_valid = 1'b0;
    if1.cmd_valid = 1'b0;
    both = 0; d0 = 0; d1 = 0;
    gap0 = 1'b0; gap1 = 1'b0; pd0 = 1'b0; pd1 = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      #1;
      if (if0.gnt && if1.gnt) both++;
      if (pd0 && !if0.req) gap0 = 1'b1;
      if (pd1 && !if1.req) gap1 = 1'b1;
      pd0 = if0.done;
      pd1 = if1.done;
      if (if0.done) d0++;
      if (if1.done) d1++;
      @(negedge clk);
    end
    use_arb = 1'b0;
    #1;
    chk("arb_both", both, 0);
    chk("arb_d0", d0, 1);
    chk("arb_d1", d1, 1);
    chk("arb_gap0", gap0, 1);
    chk("arb_gap1", gap1, 1);
    chk("arb_rdy0", if0.cmd_ready, 1);
    chk("arb_rdy1", if1.cmd_ready, 1);

    // Grant-wait timeout
    @(negedge clk);
    sg0 = 1'b0;
    if0.cmd_valid = 1'b1;
    if0.cmd_len   = 4'd1;
    @(negedge clk);
    if0.cmd_valid = 1'b0;
`ifdef REQ_TIMEOUT_EN
    tos = 0; to_at = 0; dones = 0; req9 = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      #1;
      if (if0.to) begin tos++; to_at = k; end
      if (if0.done) dones++;
      if (k == 9) req9 = if0.req;
      @(negedge clk);
    end
    chk("to_count", tos, 1);
    chk("to_at", to_at, 8);
    chk("to_req_drop", req9, 0);
    chk("to_no_done", dones, 0);
`else
    reqs = 0; tos = 0;
    for (int k = 1; k <= 100; k++) begin
      #1;
      if (if0.req) reqs++;
      if (if0.to) tos++;
      @(negedge clk);
    end
    chk("nto_req_held", reqs, 100);
    chk("nto_to", tos, 0);
    sg0 = 1'b1;
    #1;
    chk("nto_g1_done", if0.done, 0);
    @(negedge clk);
    #1;
    chk("nto_g2_done", if0.done, 1);
    @(negedge clk);
    sg0 = 1'b0;
`endif

    // Reset in the middle of OWN on both channels
    @(negedge clk);
    @(negedge clk);
    sg0 = 1'b1;
    sg1 = 1'b1;
    if0.cmd_valid = 1'b1;
    if0.cmd_len   = 4'd5;
    if1.cmd_valid = 1'b1;
    if1.cmd_len   = 4'd5;
    @(negedge clk);
    if0.cmd_valid = 1'b0;
    if1.cmd_valid = 1'b0;
    @(negedge clk);
    #1;
    chk("mr_own_req0", if0.req, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mr_req0", if0.req, 0);
    chk("mr_req1", if1.req, 0);
    chk("mr_done0", if0.done, 0);
    chk("mr_done1", if1.done, 0);
    chk("mr_rdy0", if0.cmd_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;
    sg0 = 1'b0;
    sg1 = 1'b0;
    #1;
    chk("mr_rel_rdy0", if0.cmd_ready, 1);
    chk("mr_rel_rdy1", if1.cmd_ready, 1);
    @(negedge clk);
    #1;
    chk("mr_post_req0", if0.req, 0);
    chk("mr_post_done0", if0.done, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
